cla_div4: RTL and testbench
===========================

CLA_DIV4 -- requirements
Module: cla_div4

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL provide port start, input, 1 bit: request a new division; sampled on the rising edge of clk.
REQ-004 SHALL provide port dividend, input, 4 bits: unsigned dividend, sampled on the start edge only.
REQ-005 SHALL provide port divisor, input, 4 bits: unsigned divisor, sampled on the start edge only.
REQ-006 SHALL provide port busy, output, 1 bit: high while a division is in progress.
REQ-007 SHALL provide port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-008 SHALL provide port quotient, output, 4 bits: registered unsigned quotient.
REQ-009 SHALL provide port remainder, output, 4 bits: registered unsigned remainder.
REQ-010 SHALL provide port div_by_zero, output, 1 bit, present only under CLA_DIV4_DBZ_EN (see Configuration).

Function
REQ-011 SHALL implement a three-state FSM:
- IDLE: start=1 -> RUN.
- RUN: after 4 iterations -> DONE.
- DONE: unconditionally -> IDLE, unless start=1, which goes to RUN.
REQ-012 SHALL, on an accepted start edge (E0), load the operand registers, clear the 5-bit partial remainder, set the iteration count to 3 and raise busy.
REQ-013 SHALL perform one restoring step per RUN edge, for i = 3 down to 0:
- R = {R[3:0], dividend[i]}
- T = R - {0,divisor}, computed as 5-bit R + ~{0,divisor} + 1 using 4-bit carry-lookahead generate/propagate logic.
- If T >= 0: R = T and q[i] = 1; otherwise R is unchanged and q[i] = 0.
REQ-014 SHALL complete the 4 iterations on edges E1..E4, then load quotient and remainder, assert done=1 and deassert busy in the cycle from E4 to E5.
REQ-015 SHALL hold done high for exactly one cycle per accepted start.
REQ-016 SHALL keep quotient and remainder stable from done until the next done, even while a new division is running.
REQ-017 SHALL ignore start while in RUN, with no effect on operands or timing.
REQ-018 SHALL accept start in DONE as a back-to-back start, giving a next done exactly 5 cycles after the previous done.
REQ-019 SHALL produce, for a zero divisor without fast path, the natural result quotient=4'hF and remainder=dividend with normal latency.

Reset
REQ-020 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0 and (if present) div_by_zero=0, independent of clk.
REQ-021 SHALL, on reset during RUN or DONE, abort the operation with no done pulse and no result update.
REQ-022 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; start sampled on that edge SHALL be accepted.

Configuration
REQ-023 SHALL, with macro CLA_DIV4_DBZ_EN defined:
- Provide the div_by_zero port.
- On a start edge with divisor=0, skip RUN and enter DONE at E0.
- Assert done, quotient=4'hF, remainder=dividend, div_by_zero=1 from E0 to E1.
- Set div_by_zero=0 on every nonzero-divisor done.
- Hold div_by_zero with the result otherwise.
REQ-024 SHALL, without CLA_DIV4_DBZ_EN, omit the div_by_zero port and treat divisor=0 per REQ-019.

Verification
REQ-025 SHALL check: dividend=13, divisor=4, start at E0 -> busy high E0..E4, done=1 E4..E5, quotient=3, remainder=1.
REQ-026 SHALL check: dividend=15, divisor=1 and dividend=2, divisor=7 -> (15,0) and (0,2), each with 4-cycle latency.
REQ-027 SHALL check: divisor=0, dividend=9:
- With CLA_DIV4_DBZ_EN: done at E0..E1, quotient=15, remainder=9, div_by_zero=1.
- Without it: same values at E4..E5.
REQ-028 SHALL check back-to-back operation: start held high continuously with new operands each DONE cycle -> done every 5 cycles, each result correct; start pulses during RUN ignored.
REQ-029 SHALL check reset mid-operation: rst_n low at E2 of 12/5 -> outputs 0 immediately, no done; a new start for 12/5 after release -> quotient=2, remainder=2.
REQ-030 SHALL check exhaustively: all 256 operand pairs -> quotient and remainder match the integer model, and done count equals start-accept count.

Source files
------------

// File: rtl/cla_div4.sv
// cla_div4: 4-bit unsigned restoring divider, one carry-lookahead subtract per cycle.
// Define CLA_DIV4_DBZ_EN for the div_by_zero port and a single-cycle zero-divisor result.
module cla_div4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder
`ifdef CLA_DIV4_DBZ_EN
    ,output logic      div_by_zero
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] a, b, q, y, g, p;
    logic [4:0] r, rs, t, c;
    logic [1:0] cnt;
    logic accept, fast, ge;
    assign accept = start && state != RUN;
`ifdef CLA_DIV4_DBZ_EN
    assign fast = accept && divisor == 4'd0;
`else
    assign fast = 1'b0;
`endif
    assign busy = state == RUN;
    assign done = state == DONE;
    // R - divisor as R + ~{0,divisor} + 1; carries into bits 1..4 are fully lookahead-expanded
    always_comb begin
        rs = {r[3:0], a[cnt]};
        y = ~b;
        g = rs[3:0] & y;
        p = rs[3:0] ^ y;
        c[0] = 1'b1;
        c[1] = g[0] | p[0];
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p);
        t = {~(rs[4] ^ c[4]), p ^ c[3:0]};
        ge = rs[4] | c[4];
        state_nxt = state == RUN ? (cnt == 2'd0 ? DONE : RUN)
                  : accept ? (fast ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            r <= '0;
            q <= '0;
            cnt <= '0;
            quotient <= '0;
            remainder <= '0;
`ifdef CLA_DIV4_DBZ_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                a <= dividend;
                b <= divisor;
                r <= '0;
                cnt <= 2'd3;
`ifdef CLA_DIV4_DBZ_EN
                if (fast) begin
                    quotient <= 4'hF;
                    remainder <= dividend;
                    div_by_zero <= 1'b1;
                end
`endif
            end else if (state == RUN) begin
                r <= ge ? t : rs;
                q <= {q[2:0], ge};
                cnt <= cnt - 2'd1;
                if (cnt == 2'd0) begin
                    quotient <= {q[2:0], ge};
                    remainder <= ge ? t[3:0] : rs[3:0];
`ifdef CLA_DIV4_DBZ_EN
                    div_by_zero <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_div4.sv
// tb_cla_div4: randomized and exhaustive self-checking bench for cla_div4 against an integer division model.
module tb_cla_div4;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] dividend = '0, divisor = '0;
    logic busy, done;
    logic [3:0] quotient, remainder;
    int errors = 0, checks = 0, accepts = 0, dones = 0;
`ifdef CLA_DIV4_DBZ_EN
    logic div_by_zero;
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    cla_div4 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
`ifdef CLA_DIV4_DBZ_EN
        , .div_by_zero(div_by_zero)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) dones++;

    function automatic logic [3:0] mq(input int dd, input int dv);
        return (dv == 0) ? 4'hF : 4'(dd / dv);
    endfunction
    function automatic logic [3:0] mr(input int dd, input int dv);
        return (dv == 0) ? 4'(dd) : 4'(dd % dv);
    endfunction

    task automatic do_div(input logic [3:0] dd, input logic [3:0] dv, input string nm);
        int n, lat;
        lat = (DBZ && dv == 4'd0) ? 0 : 4;
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk);
        #1 start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
        accepts++;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != lat) begin errors++; $display("FAIL %s_latency %0d/%0d: got %0d expected %0d", nm, dd, dv, n, lat); end
        checks++;
        if (quotient !== mq(dd, dv) || remainder !== mr(dd, dv) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result %0d/%0d: got q=%0d r=%0d busy=%b expected q=%0d r=%0d busy=0",
                     nm, dd, dv, quotient, remainder, busy, mq(dd, dv), mr(dd, dv));
        end
`ifdef CLA_DIV4_DBZ_EN
        checks++;
        if (div_by_zero !== (dv == 4'd0)) begin errors++; $display("FAIL %s_dbz %0d/%0d: got %b expected %b", nm, dd, dv, div_by_zero, dv == 4'd0); end
`endif
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s_pulse %0d/%0d: got done=%b expected 0", nm, dd, dv, done); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder} !== 10'd0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b q=%0d r=%0d expected all 0", busy, done, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        @(posedge clk);
        #1 start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
        accepts++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_busy cycle %0d: got busy=%b done=%b expected busy=1 done=0", k, busy, done); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b q=%0d r=%0d expected done=1 busy=0 q=3 r=1", done, busy, quotient, remainder);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got done=%b expected 0", done); end
    endtask

    task automatic test_corners();
        do_div(4'd15, 4'd1, "max_by_one");
        do_div(4'd2, 4'd7, "small_by_big");
        do_div(4'd9, 4'd0, "zero_div");
        do_div(4'd7, 4'd3, "after_zero");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) do_div(4'($urandom), 4'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        logic [3:0] dd[5], dv[5];
        logic [3:0] hq, hr;
        int k = 0, cyc = 0, last = -1;
        for (int i = 0; i < 5; i++) begin
            dd[i] = 4'($urandom);
            dv[i] = 4'($urandom_range(1, 15));
        end
        hq = quotient; hr = remainder;
        @(negedge clk);
        start = 1'b1; dividend = dd[0]; divisor = dv[0];
        while (k < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                checks++;
                if (quotient !== mq(dd[k], dv[k]) || remainder !== mr(dd[k], dv[k])) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got q=%0d r=%0d expected q=%0d r=%0d", k, quotient, remainder, mq(dd[k], dv[k]), mr(dd[k], dv[k]));
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin errors++; $display("FAIL b2b_spacing %0d: got %0d expected 5", k, cyc - last); end
                end
                last = cyc; hq = quotient; hr = remainder;
                k++;
                accepts++;
                if (k < 5) begin dividend = dd[k]; divisor = dv[k]; end else start = 1'b0;
            end else begin
                checks++;
                if (quotient !== hq || remainder !== hr) begin
                    errors++;
                    $display("FAIL b2b_hold: got q=%0d r=%0d expected q=%0d r=%0d", quotient, remainder, hq, hr);
                end
                dividend = 4'($urandom); divisor = 4'($urandom_range(1, 15));
            end
        end
        checks++;
        if (k != 5) begin errors++; $display("FAIL b2b_timeout: got %0d results expected 5", k); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder} !== 10'd0) begin
            errors++;
            $display("FAIL rst_async: got busy=%b done=%b q=%0d r=%0d expected all 0", busy, done, quotient, remainder);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || quotient !== 4'd0) begin errors++; $display("FAIL rst_hold cycle %0d: got done=%b q=%0d expected done=0 q=0", k, done, quotient); end
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_div(4'd12, 4'd5, "after_reset");
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                do_div(4'(i), 4'(j), "exhaustive");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_rst_mid();
        test_exhaustive();
        repeat (2) @(negedge clk);
        checks++;
        if (dones != accepts) begin errors++; $display("FAIL done_count: got %0d expected %0d", dones, accepts); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
